mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one single-outstanding memory port (start/done handshake) between NUM_REQ requesters, e.g. several matrix-multiply engines doing LOAD/STORE word transfers. It captures one requester's address, data and direction, runs exactly one memory transaction, and returns the read data and a done pulse to that requester only. It sits between the engines' memory-transaction ports and the shared memory model/controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, WAIT-state limit (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_start  in  NUM_REQ  per-requester level request; held until that requester's req_done
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  flat, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flat, requester i at [i*DATA_W +: DATA_W]
req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
req_err  out  1  qualifies req_done: transaction timed out
req_rdata  out  DATA_W  read data, valid in the req_done cycle
mem_start  out  1  one-cycle transaction strobe
mem_we  out  1  direction, held from mem_start through completion
mem_addr  out  ADDR_W  held from mem_start through completion
mem_wdata  out  DATA_W  held from mem_start through completion
mem_done  in  1  memory completion pulse
mem_rdata  in  DATA_W  valid with mem_done
busy  out  1  high in every state except IDLE
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority first. Reset mid-transaction abandons it without a req_done; memory side is reset by the same rst.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE, cycle t: if any req_start, pick the first set bit searching rr_ptr+1, rr_ptr+2 … with wrap modulo NUM_REQ. Register grant_id, mem_addr, mem_wdata and mem_we from that requester, then go to ISSUE. If no request, stay in IDLE.
- ISSUE, t+1: mem_start=1 for exactly this cycle, then go to WAIT. mem_done is ignored in ISSUE; memory responds no earlier than the next cycle.
- WAIT: hold mem_* stable.
  - On mem_done in cycle k: at k+1, req_done[grant_id]=1 and req_rdata=mem_rdata (writes: the mem_rdata value is passed through and ignored by the requester); rr_ptr<=grant_id; go to RELEASE.
- RELEASE, k+1: req_done pulse cycle; requests are not sampled. Go to IDLE at k+2.
- Requester contract: deassert req_start no later than the edge ending its req_done cycle. Back-to-back requests from the same requester re-arbitrate.
- Minimum turnaround: 4 cycles per transaction with a 1-cycle memory.
- A request dropped before grant is simply not served. A request dropped after capture is still completed and still gets its req_done.
- req_rdata and grant_id hold their values between transactions. req_done and req_err are 0 except in the RELEASE cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.

Optional Feature:
MEM_PORT_ARBITER_TIMEOUT_EN
- Defined:
  - A WAIT cycle counter, cleared on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without mem_done, go to RELEASE with req_done[grant_id]=1, req_err=1 and req_rdata=0; rr_ptr advances.
  - A late mem_done arriving in IDLE, ISSUE or RELEASE is ignored.
- Not defined: WAIT waits indefinitely, req_err is tied 0, and no counter logic exists.

Decomposition:
- Shared package: state encoding (IDLE=0, ISSUE=1, WAIT=2, RELEASE=3), and a clog2 function or constant for the grant_id width.
- One sub-module: rr_pick. Combinational, with inputs req vector and rr_ptr, and outputs found and index. It is reusable by a later engine-level job scheduler.

Test Plan:
- Single read: req_start[0]=1, addr 0x100, memory returns 0xDEAD after 3 cycles. Expect mem_start at t+1 with mem_addr=0x100, then req_done[0] and req_rdata=0xDEAD at mem_done+1.
- All four requesters held high continuously. Expect grant order 0,1,2,3,0; no requester is granted twice before all others have been granted once.
- Write from requester 2 (we=1, addr 0x20, wdata 0x1234). Expect mem_we=1 with addr/wdata held stable through WAIT; only req_done[2] pulses.
- Requester 1 drops req_start after capture. Expect the transaction still completes and req_done[1] still pulses; a requester that drops before grant gets no transaction.
- rst asserted in WAIT. Expect all outputs 0 next cycle; the first grant after reset goes to requester 0.
- With the macro and TIMEOUT_CYCLES=8, mem_done never arrives. Expect req_done and req_err at WAIT entry+8+1 with req_rdata=0; a later mem_done is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding
// and the grant index width helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching
// ptr+1, ptr+2, ... modulo NUM_REQ.
// Ports: req (request vector), ptr (last winner), found, index.
module mem_port_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        index = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port
// (start/done handshake) between NUM_REQ requesters.
// Ports: clk, rst (sync, active high); req_start/req_we/req_addr/
// req_wdata per requester (flat vectors); req_done (one-hot pulse),
// req_err, req_rdata back to the winner; mem_start/mem_we/mem_addr/
// mem_wdata to memory, mem_done/mem_rdata from memory; busy, grant_id.
// Optional macro MEM_PORT_ARBITER_TIMEOUT_EN: abort a WAIT after
// TIMEOUT_CYCLES cycles with req_err set and req_rdata zero.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int ID_W           = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_start,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_done,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("mem_port_arbiter: parameter out of range");
  end

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               wait_tmo;

  mem_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req_start),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign grant_onehot = NUM_REQ'(1) << grant_id;
  assign busy         = (state != ST_IDLE);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) begin
      wait_cnt <= '0;
    end else if (!wait_tmo) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign wait_tmo = (state == ST_WAIT) &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // A real mem_done in the same cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_err <= 1'b0;
    end else begin
      req_err <= wait_tmo && !mem_done;
    end
  end
`else
  assign wait_tmo = 1'b0;
  assign req_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      grant_id  <= '0;
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_done  <= '0;
      req_rdata <= '0;
    end else begin
      mem_start <= 1'b0;
      req_done  <= '0;
      unique case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            mem_we    <= req_we[pick_idx];
            mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            mem_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_done) begin
            req_done  <= grant_onehot;
            req_rdata <= mem_rdata;
            rr_ptr    <= grant_id;
            state     <= ST_RELEASE;
          end else if (wait_tmo) begin
            req_done  <= grant_onehot;
            req_rdata <= '0;
            rr_ptr    <= grant_id;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory,
// a round-robin reference model, and directed corner cases.
module tb_mem_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int IDW = 2;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_start, req_we, req_done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            req_err;
  logic [DW-1:0]   req_rdata;
  logic            mem_start, mem_we;
  logic            mem_done = 1'b0;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_start(req_start), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .mem_start(mem_start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  int   grant_log[$];
  int   start_log[$];

  int            mode        = 0;
  int            fixed_lat   = 0;
  logic [DW-1:0] fixed_rdata = '0;
  bit            hang        = 1'b0;
  int            late_at     = -1;
  bit            pending     = 1'b0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Spec rule: first requester found searching last+1, last+2, ...
  function automatic int model_pick(input logic [N-1:0] r,
                                    input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Memory model plus grant prediction, driven away from posedge.
  logic [N-1:0]     snap_req, snap_we;
  logic [N*AW-1:0]  snap_addr;
  logic [N*DW-1:0]  snap_wdata;
  logic [AW+DW:0]   cap;
  int               last = N - 1;
  int               cur_id, lat_cnt, wait_n;

  always @(negedge clk) begin : mem_model
    int   exp_id;
    exp_t e;
    mem_done = 1'b0;
    if (rst) begin
      pending = 1'b0;
      last    = N - 1;
    end else if (mem_start) begin
      if (pending) fail("overlap_start", "mem_start while busy");
      exp_id = model_pick(snap_req, last);
      if (exp_id < 0) begin
        fail("spurious_start", "mem_start with no request");
        cur_id = int'(grant_id);
      end else begin
        check("grant_id", grant_id, exp_id);
        check("cap_we", mem_we, snap_we[exp_id]);
        check("cap_addr", mem_addr, snap_addr[exp_id*AW +: AW]);
        check("cap_wdata", mem_wdata, snap_wdata[exp_id*DW +: DW]);
        last   = exp_id;
        cur_id = exp_id;
      end
      grant_log.push_back(int'(grant_id));
      start_log.push_back(cyc);
      cap     = {mem_we, mem_addr, mem_wdata};
      pending = 1'b1;
      wait_n  = 0;
      lat_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (pending) begin
      check("hold", {mem_we, mem_addr, mem_wdata}, cap);
      wait_n++;
      if (!hang) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_done  = 1'b1;
          mem_rdata = (fixed_lat > 0) ? fixed_rdata : $urandom;
          e.id = cur_id; e.rdata = mem_rdata; e.err = 1'b0; e.cyc = cyc;
          sbq.push_back(e);
          pending = 1'b0;
        end
      end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      else if (wait_n == TMO + 1) begin
        e.id = cur_id; e.rdata = '0; e.err = 1'b1; e.cyc = cyc;
        sbq.push_back(e);
        pending = 1'b0;
      end
`endif
    end else if (cyc == late_at) begin
      mem_done  = 1'b1;
      mem_rdata = $urandom;
    end
    snap_req   = req_start;
    snap_we    = req_we;
    snap_addr  = req_addr;
    snap_wdata = req_wdata;
  end

  // Response monitor: pops the scoreboard whenever req_done appears.
  always @(negedge clk) begin : monitor
    exp_t         e;
    logic [N-1:0] ev;
    if (rst) begin
      sbq.delete();
    end else if (req_done != '0 || req_err) begin
      if (sbq.size() == 0) begin
        fail("unexpected_done",
             $sformatf("req_done=%b err=%b", req_done, req_err));
      end else begin
        e  = sbq.pop_front();
        ev = '0;
        ev[e.id] = 1'b1;
        check("done_vec", req_done, ev);
        check("done_rdata", req_rdata, e.rdata);
        check("done_err", req_err, e.err);
        check("done_latency", cyc - e.cyc, 1);
      end
    end else if (sbq.size() > 0 && cyc - sbq[0].cyc > 1) begin
      fail("missing_done", $sformatf("req %0d never done", sbq[0].id));
      void'(sbq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_done[i]) begin
        req_start[i] = 1'b0;
      end else if (mode == 1) begin
        if (req_start[i]) begin
          if ($urandom_range(0, 31) == 0) req_start[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_start[i] = 1'b1;
          req_we[i]    = 1'($urandom);
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end else if (mode == 2 && !req_start[i]) begin
        req_start[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int max, output logic [N-1:0] seen);
    int k;
    seen = '0;
    for (k = 0; k < max; k++) begin
      step();
      seen |= req_done;
      if (!busy && req_start == '0 && sbq.size() == 0 && !pending) break;
    end
    if (k == max) fail("idle_timeout", "arbiter did not go idle");
  endtask

  task automatic wait_start(input int max);
    int k;
    for (k = 0; k < max && !mem_start; k++) step();
    if (!mem_start) fail("start_timeout", "no mem_start");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_done"}, req_done, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_req_rdata"}, req_rdata, 0);
    check({tag, "_mem_start"}, mem_start, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0] seen;
    int           g0;
    rst       = 1'b1;
    req_start = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) step();
    @(negedge clk);
    check_zero("reset");
    step();
    rst = 1'b0;

    // All requesters held: order 0,1,2,3,0 at 4-cycle turnaround.
    fixed_lat = 1;
    g0 = grant_log.size();
    mode = 2;
    for (int k = 0; k < 200 && grant_log.size() < g0 + 5; k++) step();
    mode = 0;
    req_start = '0;
    wait_idle(100, seen);
    if (grant_log.size() < g0 + 5) begin
      fail("rr_count", "fewer than five grants");
    end else begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_order%0d", k), grant_log[g0+k], k % N);
        if (k > 0)
          check("turnaround", start_log[g0+k] - start_log[g0+k-1], 4);
      end
    end

    // Single read from requester 0.
    fixed_lat   = 3;
    fixed_rdata = 32'hDEAD;
    req_we[0]   = 1'b0;
    req_addr[0*AW +: AW] = 32'h100;
    req_start[0] = 1'b1;
    wait_idle(50, seen);
    check("rd_done_vec", seen, 4'b0001);
    check("rd_rdata_hold", req_rdata, 32'hDEAD);
    check("rd_addr_hold", mem_addr, 32'h100);

    // Write from requester 2.
    fixed_lat   = 4;
    fixed_rdata = 32'h5555;
    req_we[2]   = 1'b1;
    req_addr[2*AW +: AW]  = 32'h20;
    req_wdata[2*DW +: DW] = 32'h1234;
    req_start[2] = 1'b1;
    wait_idle(50, seen);
    check("wr_done_vec", seen, 4'b0100);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 32'h20);
    check("wr_wdata", mem_wdata, 32'h1234);

    // Requester 1 drops after capture; requester 3 drops before grant.
    req_we[1] = 1'b0;
    req_addr[1*AW +: AW] = 32'h44;
    req_start[1] = 1'b1;
    g0 = grant_log.size();
    wait_start(20);
    req_start[1] = 1'b0;
    req_start[3] = 1'b1;
    req_addr[3*AW +: AW] = 32'h33;
    step();
    req_start[3] = 1'b0;
    wait_idle(50, seen);
    repeat (4) step();
    check("drop_done_vec", seen, 4'b0010);
    check("drop_grants", grant_log.size() - g0, 1);

    // Reset while in WAIT abandons the transaction.
    hang = 1'b1;
    req_start[3] = 1'b1;
    wait_start(20);
    step();
    step();
    req_start[3] = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    check_zero("mid_reset");
    step();
    rst  = 1'b0;
    hang = 1'b0;
    fixed_lat = 2;
    req_start = 4'b1001;
    wait_start(20);
    check("post_reset_grant", grant_id, 0);
    wait_idle(100, seen);
    check("post_reset_done", seen, 4'b1001);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Memory never answers: timeout, then a late mem_done is ignored.
    hang = 1'b1;
    req_start[1] = 1'b1;
    wait_idle(60, seen);
    hang = 1'b0;
    check("tmo_done_vec", seen, 4'b0010);
    check("tmo_rdata", req_rdata, 0);
    g0 = grant_log.size();
    late_at = cyc + 2;
    repeat (6) step();
    check("tmo_late_busy", busy, 0);
    check("tmo_late_grants", grant_log.size() - g0, 0);
`endif

    // Random traffic against the scoreboard.
    fixed_lat = 0;
    mode = 1;
    repeat (3000) step();
    mode = 0;
    req_start = '0;
    wait_idle(100, seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
